// File: rtl/reg_pkg.sv
// Architectural/physical register file sizing and tag types shared by the rename path.
package reg_pkg;

    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned NUM_PHYS_REGS = 64;
    localparam int unsigned ATAG_W        = $clog2(NUM_ARCH_REGS);
    localparam int unsigned PTAG_W        = $clog2(NUM_PHYS_REGS);

    typedef logic [ATAG_W-1:0] atag_t;
    typedef logic [PTAG_W-1:0] ptag_t;

endpackage

// File: rtl/uop_pkg.sv
// Uop group geometry and the renamed-uop record handed to dispatch/ROB.
package uop_pkg;

    import reg_pkg::*;

    localparam int unsigned INSTR_Q_WIDTH = 4;

    typedef struct packed {
        logic  slot_valid;
        ptag_t psrc1;
        ptag_t psrc2;
        ptag_t pdst;
        ptag_t old_pdst;
    } renamed_uop_t;

endpackage

// File: rtl/rat_table.sv
// Register alias table: WIDTH ordered write ports (highest slot wins), whole-table
// asynchronous read, and a whole-table load that overrides the writes. Resets to identity.
module rat_table #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned DATA_W = 6,
    parameter bit          BYPASS = 1'b0,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [DEPTH*DATA_W-1:0] load_data,
    input  logic [WIDTH-1:0]        wr_en,
    input  logic [WIDTH*ADDR_W-1:0] wr_addr,
    input  logic [WIDTH*DATA_W-1:0] wr_data,
    output logic [DEPTH*DATA_W-1:0] rd_all
);

    logic [DEPTH-1:0][DATA_W-1:0] map_q, map_d;

    always_comb begin
        map_d = map_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (wr_en[i]) begin
                map_d[wr_addr[i*ADDR_W +: ADDR_W]] = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // BYPASS exposes the post-write contents so a same-cycle load elsewhere sees them.
    assign rd_all = BYPASS ? map_d : map_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                map_q[i] <= DATA_W'(i);
            end
        end else if (load) begin
            map_q <= load_data;
        end else begin
            map_q <= map_d;
        end
    end

endmodule

// File: rtl/rename_rat.sv
// Rename stage: maps a uop group's architectural operands to physical tags with
// intra-group bypass, tracks a committed map, and restores from it on flush.
module rename_rat #(
    parameter int unsigned WIDTH         = uop_pkg::INSTR_Q_WIDTH,
    parameter int unsigned NUM_ARCH_REGS = reg_pkg::NUM_ARCH_REGS,
    parameter int unsigned NUM_PHYS_REGS = reg_pkg::NUM_PHYS_REGS,
    localparam int unsigned PTAG_W = $clog2(NUM_PHYS_REGS),
    localparam int unsigned ATAG_W = $clog2(NUM_ARCH_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_slot_valid,
    input  logic [WIDTH*ATAG_W-1:0]   in_src1,
    input  logic [WIDTH*ATAG_W-1:0]   in_src2,
    input  logic [WIDTH*ATAG_W-1:0]   in_dst,
    input  logic [WIDTH-1:0]          in_dst_valid,
    input  logic                      frl_valid,
    input  logic [3*WIDTH*PTAG_W-1:0] frl_regs,
    output logic [3*WIDTH-1:0]        frl_acquire,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_slot_valid,
    output logic [WIDTH*PTAG_W-1:0]   out_psrc1,
    output logic [WIDTH*PTAG_W-1:0]   out_psrc2,
    output logic [WIDTH*PTAG_W-1:0]   out_pdst,
    output logic [WIDTH*PTAG_W-1:0]   out_old_pdst,
    input  logic [WIDTH-1:0]          commit_valid,
    input  logic [WIDTH-1:0]          commit_dst_valid,
    input  logic [WIDTH*ATAG_W-1:0]   commit_dst,
    input  logic [WIDTH*PTAG_W-1:0]   commit_pdst,
    input  logic [WIDTH*PTAG_W-1:0]   commit_old_pdst,
    output logic [WIDTH-1:0]          free_valid,
    output logic [WIDTH*PTAG_W-1:0]   free_regs,
    input  logic                      flush
);

    localparam int unsigned IDX_W = $clog2(3 * WIDTH);

    logic [WIDTH-1:0][ATAG_W-1:0]     src1_v, src2_v, dst_v;
    logic [3*WIDTH-1:0][PTAG_W-1:0]   frl_v;
    logic [WIDTH-1:0][PTAG_W-1:0]     commit_old_v;
    logic [NUM_ARCH_REGS-1:0][PTAG_W-1:0] spec_rd, commit_nxt;

    logic [WIDTH-1:0][PTAG_W-1:0] psrc1_d, psrc2_d, pdst_d, old_pdst_d, free_regs_d;
    logic [WIDTH-1:0]             alloc, commit_fire;
    logic [IDX_W-1:0]             cnt;
    logic                         accept;

    assign src1_v       = in_src1;
    assign src2_v       = in_src2;
    assign dst_v        = in_dst;
    assign frl_v        = frl_regs;
    assign commit_old_v = commit_old_pdst;

    assign alloc       = in_slot_valid & in_dst_valid;
    assign commit_fire = commit_valid & commit_dst_valid;
    assign in_ready    = frl_valid & (~out_valid | out_ready) & ~flush & ~rst;
    assign accept      = in_valid & in_ready;

    always_comb begin
        cnt        = '0;
        psrc1_d    = '0;
        psrc2_d    = '0;
        pdst_d     = '0;
        old_pdst_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (alloc[i]) begin
                pdst_d[i] = frl_v[cnt];
                cnt       = cnt + IDX_W'(1);
            end
            if (in_slot_valid[i]) begin
                psrc1_d[i] = spec_rd[src1_v[i]];
                psrc2_d[i] = spec_rd[src2_v[i]];
                if (alloc[i]) old_pdst_d[i] = spec_rd[dst_v[i]];
                // Ascending scan leaves the youngest older producer in place.
                for (int j = 0; j < i; j++) begin
                    if (alloc[j] && dst_v[j] == src1_v[i]) psrc1_d[i] = pdst_d[j];
                    if (alloc[j] && dst_v[j] == src2_v[i]) psrc2_d[i] = pdst_d[j];
                    if (alloc[j] && alloc[i] && dst_v[j] == dst_v[i]) old_pdst_d[i] = pdst_d[j];
                end
            end
        end
    end

    always_comb begin
        frl_acquire = '0;
        for (int j = 0; j < WIDTH; j++) begin
            frl_acquire[j] = accept && (IDX_W'(j) < cnt);
        end
    end

    always_comb begin
        free_regs_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (commit_fire[i]) free_regs_d[i] = commit_old_v[i];
        end
    end

    rat_table #(
        .WIDTH  (WIDTH),
        .DEPTH  (NUM_ARCH_REGS),
        .DATA_W (PTAG_W),
        .BYPASS (1'b0)
    ) u_spec_map (
        .clk       (clk),
        .rst       (rst),
        .load      (flush),
        .load_data (commit_nxt),
        .wr_en     (alloc & {WIDTH{accept}}),
        .wr_addr   (in_dst),
        .wr_data   (pdst_d),
        .rd_all    (spec_rd)
    );

    rat_table #(
        .WIDTH  (WIDTH),
        .DEPTH  (NUM_ARCH_REGS),
        .DATA_W (PTAG_W),
        .BYPASS (1'b1)
    ) u_commit_map (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .wr_en     (commit_fire),
        .wr_addr   (commit_dst),
        .wr_data   (commit_pdst),
        .rd_all    (commit_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_slot_valid <= '0;
            out_psrc1      <= '0;
            out_psrc2      <= '0;
            out_pdst       <= '0;
            out_old_pdst   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_slot_valid <= in_slot_valid;
            out_psrc1      <= psrc1_d;
            out_psrc2      <= psrc2_d;
            out_pdst       <= pdst_d;
            out_old_pdst   <= old_pdst_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_valid <= '0;
            free_regs  <= '0;
        end else begin
            free_valid <= commit_fire;
            free_regs  <= free_regs_d;
        end
    end

endmodule

// File: tb/tb_rename_rat.sv
// Directed bench for rename_rat: table of rename groups plus hand sequences for
// backpressure, commit/free, flush restore and asynchronous reset.
module tb_rename_rat;

    typedef logic [3:0][4:0] a4_t;
    typedef logic [3:0][5:0] p4_t;

    typedef struct {
        logic [3:0] sv;
        logic [3:0] dv;
        a4_t        src1;
        a4_t        src2;
        a4_t        dst;
        p4_t        frl;
        p4_t        e_ps1;
        p4_t        e_ps2;
        p4_t        e_pd;
        p4_t        e_old;
        logic [3:0] e_acq;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_slot_valid = '0;
    logic [19:0] in_src1 = '0, in_src2 = '0, in_dst = '0;
    logic [3:0]  in_dst_valid = '0;
    logic        frl_valid = 1'b1;
    logic [71:0] frl_regs = '0;
    logic [11:0] frl_acquire;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_slot_valid;
    logic [23:0] out_psrc1, out_psrc2, out_pdst, out_old_pdst;
    logic [3:0]  commit_valid = '0, commit_dst_valid = '0;
    logic [19:0] commit_dst = '0;
    logic [23:0] commit_pdst = '0, commit_old_pdst = '0;
    logic [3:0]  free_valid;
    logic [23:0] free_regs;
    logic        flush = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[5];
    vec_t g;

    always #5 clk = ~clk;

    rename_rat dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_slot_valid    (in_slot_valid),
        .in_src1          (in_src1),
        .in_src2          (in_src2),
        .in_dst           (in_dst),
        .in_dst_valid     (in_dst_valid),
        .frl_valid        (frl_valid),
        .frl_regs         (frl_regs),
        .frl_acquire      (frl_acquire),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_slot_valid   (out_slot_valid),
        .out_psrc1        (out_psrc1),
        .out_psrc2        (out_psrc2),
        .out_pdst         (out_pdst),
        .out_old_pdst     (out_old_pdst),
        .commit_valid     (commit_valid),
        .commit_dst_valid (commit_dst_valid),
        .commit_dst       (commit_dst),
        .commit_pdst      (commit_pdst),
        .commit_old_pdst  (commit_old_pdst),
        .free_valid       (free_valid),
        .free_regs        (free_regs),
        .flush            (flush)
    );

    function automatic a4_t a4(int s0, int s1, int s2, int s3);
        a4_t r;
        r[0] = 5'(s0); r[1] = 5'(s1); r[2] = 5'(s2); r[3] = 5'(s3);
        return r;
    endfunction

    function automatic p4_t p4(int s0, int s1, int s2, int s3);
        p4_t r;
        r[0] = 6'(s0); r[1] = 6'(s1); r[2] = 6'(s2); r[3] = 6'(s3);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_slot_valid = v.sv;
        in_dst_valid  = v.dv;
        in_src1       = v.src1;
        in_src2       = v.src2;
        in_dst        = v.dst;
        frl_regs      = {48'b0, v.frl};
    endtask

    task automatic chk_out(input string nm, input vec_t v);
        chk({nm, ".out_valid"}, 72'(out_valid), 72'(1'b1));
        chk({nm, ".slot_valid"}, 72'(out_slot_valid), 72'(v.sv));
        chk({nm, ".psrc1"}, 72'(out_psrc1), 72'(v.e_ps1));
        chk({nm, ".psrc2"}, 72'(out_psrc2), 72'(v.e_ps2));
        chk({nm, ".pdst"}, 72'(out_pdst), 72'(v.e_pd));
        chk({nm, ".old_pdst"}, 72'(out_old_pdst), 72'(v.e_old));
    endtask

    initial begin
        // Single rename after reset.
        vecs[0] = '{sv: 4'b0001, dv: 4'b0001, src1: a4(3, 0, 0, 0), src2: a4(0, 0, 0, 0),
                    dst: a4(5, 0, 0, 0), frl: p4(40, 41, 42, 43),
                    e_ps1: p4(3, 0, 0, 0), e_ps2: p4(0, 0, 0, 0), e_pd: p4(40, 0, 0, 0),
                    e_old: p4(5, 0, 0, 0), e_acq: 4'b0001};
        // Intra-group bypass on r7.
        vecs[1] = '{sv: 4'b0111, dv: 4'b0011, src1: a4(1, 7, 0, 0), src2: a4(2, 5, 7, 0),
                    dst: a4(7, 7, 0, 0), frl: p4(41, 42, 44, 45),
                    e_ps1: p4(1, 41, 0, 0), e_ps2: p4(2, 40, 42, 0), e_pd: p4(41, 42, 0, 0),
                    e_old: p4(7, 41, 0, 0), e_acq: 4'b0011};
        // Gap in allocation; invalid slot 3 carries a dst that must be ignored.
        vecs[2] = '{sv: 4'b0111, dv: 4'b1101, src1: a4(7, 5, 9, 3), src2: a4(5, 3, 7, 3),
                    dst: a4(5, 0, 9, 3), frl: p4(46, 47, 48, 49),
                    e_ps1: p4(42, 46, 9, 0), e_ps2: p4(40, 3, 42, 0), e_pd: p4(46, 0, 47, 0),
                    e_old: p4(40, 0, 9, 0), e_acq: 4'b0011};
        // Full group, repeated dst r9.
        vecs[3] = '{sv: 4'b1111, dv: 4'b1111, src1: a4(9, 9, 9, 3), src2: a4(5, 0, 3, 9),
                    dst: a4(9, 9, 3, 9), frl: p4(50, 51, 52, 53),
                    e_ps1: p4(47, 50, 51, 52), e_ps2: p4(46, 0, 3, 51), e_pd: p4(50, 51, 52, 53),
                    e_old: p4(47, 50, 3, 51), e_acq: 4'b1111};
        // Read back the speculative map; top arch reg r31.
        vecs[4] = '{sv: 4'b0111, dv: 4'b0100, src1: a4(9, 7, 0, 0), src2: a4(3, 5, 31, 0),
                    dst: a4(0, 0, 31, 0), frl: p4(54, 55, 56, 57),
                    e_ps1: p4(53, 42, 0, 0), e_ps2: p4(52, 46, 31, 0), e_pd: p4(0, 0, 54, 0),
                    e_old: p4(0, 0, 31, 0), e_acq: 4'b0001};

        // Reset state; in_ready must stay low while rst is high.
        in_valid = 1'b1;
        drive(vecs[0]);
        repeat (2) @(negedge clk);
        chk("rst.in_ready", 72'(in_ready), 72'(0));
        chk("rst.out_valid", 72'(out_valid), 72'(0));
        chk("rst.out_psrc1", 72'(out_psrc1), 72'(0));
        chk("rst.free_valid", 72'(free_valid), 72'(0));
        chk("rst.free_regs", 72'(free_regs), 72'(0));
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            drive(vecs[k]);
            in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d.in_ready", k), 72'(in_ready), 72'(1));
            chk($sformatf("v%0d.acquire", k), 72'(frl_acquire), 72'(vecs[k].e_acq));
            @(negedge clk);
            in_valid = 1'b0;
            chk_out($sformatf("v%0d", k), vecs[k]);
        end

        // Backpressure: held output blocks intake and acquisition.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(vecs[3]);
        #1;
        chk("bp.in_ready", 72'(in_ready), 72'(0));
        chk("bp.acquire", 72'(frl_acquire), 72'(0));
        @(negedge clk);
        chk_out("bp.hold", vecs[4]);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("bp.drain", 72'(out_valid), 72'(0));
        frl_valid = 1'b0;
        in_valid  = 1'b1;
        drive(vecs[0]);
        #1;
        chk("nofrl.in_ready", 72'(in_ready), 72'(0));
        chk("nofrl.acquire", 72'(frl_acquire), 72'(0));
        @(negedge clk);
        chk("nofrl.out_valid", 72'(out_valid), 72'(0));
        frl_valid = 1'b1;
        in_valid  = 1'b0;

        // Commit r5->40; slot 2 retires without a destination.
        commit_valid     = 4'b0101;
        commit_dst_valid = 4'b0001;
        commit_dst       = a4(5, 0, 9, 0);
        commit_pdst      = p4(40, 0, 0, 0);
        commit_old_pdst  = p4(5, 0, 33, 0);
        @(negedge clk);
        chk("commit.free_valid", 72'(free_valid), 72'(4'b0001));
        chk("commit.free_regs", 72'(free_regs), 72'(p4(5, 0, 0, 0)));
        commit_valid = '0;
        @(negedge clk);
        chk("commit.free_clear", 72'(free_valid), 72'(0));

        // Flush with a same-cycle commit of r3->52; r9 (uncommitted 53) must revert.
        g = vecs[0];
        g.sv = 4'b0001; g.dv = 4'b0000; g.src1 = a4(0, 0, 0, 0);
        drive(g);
        in_valid = 1'b1;
        @(negedge clk);
        chk("fl.pre_valid", 72'(out_valid), 72'(1));
        out_ready = 1'b0;
        flush     = 1'b1;
        drive(vecs[3]);
        commit_valid     = 4'b0001;
        commit_dst_valid = 4'b0001;
        commit_dst       = a4(3, 0, 0, 0);
        commit_pdst      = p4(52, 0, 0, 0);
        commit_old_pdst  = p4(3, 0, 0, 0);
        #1;
        chk("fl.in_ready", 72'(in_ready), 72'(0));
        chk("fl.acquire", 72'(frl_acquire), 72'(0));
        @(negedge clk);
        chk("fl.out_valid", 72'(out_valid), 72'(0));
        chk("fl.free_valid", 72'(free_valid), 72'(4'b0001));
        chk("fl.free_regs", 72'(free_regs), 72'(p4(3, 0, 0, 0)));
        flush     = 1'b0;
        out_ready = 1'b1;
        g.sv = 4'b0011; g.dv = 4'b0000;
        g.src1 = a4(9, 3, 0, 0); g.src2 = a4(5, 7, 0, 0); g.dst = a4(0, 0, 0, 0);
        g.e_ps1 = p4(9, 52, 0, 0); g.e_ps2 = p4(40, 7, 0, 0);
        g.e_pd = p4(0, 0, 0, 0); g.e_old = p4(0, 0, 0, 0);
        drive(g);
        // Concurrent commit leaves a free pending for the reset check.
        commit_valid     = 4'b0010;
        commit_dst_valid = 4'b0010;
        commit_dst       = a4(0, 9, 0, 0);
        commit_pdst      = p4(0, 53, 0, 0);
        commit_old_pdst  = p4(0, 9, 0, 0);
        @(negedge clk);
        chk_out("fl.restore", g);
        chk("fl.free2", 72'(free_valid), 72'(4'b0010));
        in_valid     = 1'b0;
        commit_valid = '0;
        out_ready    = 1'b0;

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        chk("arst.out_valid", 72'(out_valid), 72'(0));
        chk("arst.free_valid", 72'(free_valid), 72'(0));
        chk("arst.in_ready", 72'(in_ready), 72'(0));
        chk("arst.out_psrc1", 72'(out_psrc1), 72'(0));
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        g.sv = 4'b0001; g.dv = 4'b0001;
        g.src1 = a4(9, 0, 0, 0); g.src2 = a4(5, 0, 0, 0); g.dst = a4(3, 0, 0, 0);
        g.frl = p4(60, 61, 62, 63);
        g.e_ps1 = p4(9, 0, 0, 0); g.e_ps2 = p4(5, 0, 0, 0);
        g.e_pd = p4(60, 0, 0, 0); g.e_old = p4(3, 0, 0, 0);
        drive(g);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("arst.identity", g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rename_rat.md
# rename_rat

Register-rename stage between the instruction queue and dispatch/ROB. It takes up to `WIDTH` decoded uops per cycle and maps their architectural sources and destinations to physical tags. New destination tags come from `frl`, and the previous mapping of each destination goes to the ROB. At commit it updates a committed map and returns each superseded physical tag to `frl`. On flush it restores the speculative map from the committed map.

## Interface
Parameters:
- `WIDTH`, default `uop_pkg::INSTR_Q_WIDTH`: uops per group.
- `NUM_ARCH_REGS`, default `reg_pkg::NUM_ARCH_REGS` (32): architectural registers.
- `NUM_PHYS_REGS`, default `reg_pkg::NUM_PHYS_REGS`: physical registers. `PTAG_W` = `$clog2(NUM_PHYS_REGS)`, `ATAG_W` = `$clog2(NUM_ARCH_REGS)`.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: a uop group is offered.
- `in_ready` out 1: the group is accepted this cycle.
- `in_slot_valid` in `WIDTH`: per-slot uop present.
- `in_src1`, `in_src2`, `in_dst` in `WIDTH`×`ATAG_W`: architectural operands.
- `in_dst_valid` in `WIDTH`: the uop writes a destination.
- `frl_valid` in 1: `acquire_valid_out` from `frl`.
- `frl_regs` in `3*WIDTH`×`PTAG_W`: `registers_out` from `frl`.
- `frl_acquire` out `3*WIDTH`: drives `acquire_ready_in` of `frl`; only the low `WIDTH` bits can be set.
- `out_valid` out 1: the renamed group is valid.
- `out_ready` in 1: downstream accepts the group.
- `out_slot_valid` out `WIDTH`: per-slot uop present in the renamed group.
- `out_psrc1`, `out_psrc2`, `out_pdst`, `out_old_pdst` out `WIDTH`×`PTAG_W`: physical tags.
- `commit_valid` in `WIDTH`: the ROB retires these slots.
- `commit_dst_valid` in `WIDTH`: the retiring slot has a destination.
- `commit_dst` in `WIDTH`×`ATAG_W`; `commit_pdst`, `commit_old_pdst` in `WIDTH`×`PTAG_W`: retirement data.
- `free_valid` out `WIDTH`; `free_regs` out `WIDTH`×`PTAG_W`: to `frl` `free_valid_in`/`freeing_registers`; the top level zero-extends to `3*WIDTH`.
- `flush` in 1: squash all speculative rename state.

## Operation
- **State:**
  - `spec_map`, `commit_map`: `NUM_ARCH_REGS`×`PTAG_W` each.
  - Output register: the renamed group.
  - Free register: `free_valid`/`free_regs`.
- **Accept rule:** `in_ready` = `frl_valid` & (!`out_valid` | `out_ready`) & !`flush`. A group is accepted when `in_valid` & `in_ready`.
- **Destination allocation:** let k = number of slots i with `in_slot_valid[i]` & `in_dst_valid[i]`, counted in slot order. The j-th such slot gets `pdst` = `frl_regs[j]`. On accept, `frl_acquire[j]` = 1 for j<k; otherwise all bits are 0.
- **Source lookup:** `psrcN[i]` comes from `spec_map[srcN]` unless a lower slot j<i with a valid dst has `dst`==`srcN`. In that case the highest such j supplies its `pdst`.
- **Old destination:** `old_pdst[i]` follows the same rule applied to `dst[i]`, so `spec_map` is used or the most recent lower slot wins.
- **Speculative map write:** on accept, write `spec_map[dst]` in slot order; the highest slot wins on a duplicate `dst`.
- **Invalid slots:** slots without `in_slot_valid` have all tags set to 0 and do not touch the map.
- **Commit:** for each slot with `commit_valid` & `commit_dst_valid`:
  - Write `commit_map[commit_dst]` ← `commit_pdst`; the highest slot wins on a duplicate.
  - Register `free_valid[i]`=1 and `free_regs[i]`=`commit_old_pdst[i]` for one cycle.
- **Flush:**
  - `spec_map` ← `commit_map` including the same-cycle commit writes.
  - `out_valid` is cleared.
  - No acquire is issued.
  - Commits and frees proceed normally.
  - Reclaiming the tags of squashed uops is the ROB's job, not this block's.
- **Reset:** `spec_map[i]` = `commit_map[i]` = i. The top level guarantees that `frl` never issues tags 0..`NUM_ARCH_REGS`-1 until they are freed.

## Timing
- Rename latency is 1 cycle: a group accepted in cycle t appears on `out_*` in t+1 and holds until `out_ready`.
- Free latency is 1 cycle: a commit in t appears on `free_valid` in t+1.
- `frl_acquire` and `in_ready` are combinational in the same cycle; `frl` advances its head on that edge.
- Simultaneous accept and commit to the same arch reg: each map updates independently, with no interaction.
- `flush` has priority over accept. With `flush` and `out_ready` in the same cycle, `out_valid` becomes 0 next cycle.
- Reset values:
  - `out_valid`=0, all `out_*` tags 0.
  - `free_valid`=0, `free_regs`=0.
  - `in_ready`=0 while `rst` is high.
- Reset mid-operation discards the in-flight group and pending frees immediately (asynchronous).

## Structure
- **`reg_pkg`:** `NUM_ARCH_REGS`, plus the typedefs `ptag_t` and `atag_t`.
- **`uop_pkg`:** `renamed_uop_t` with fields `slot_valid`, `psrc1`, `psrc2`, `pdst`, `old_pdst`.
- **Sub-module `rat_table`:** a map array with `WIDTH` ordered write ports, asynchronous read, and a whole-table load. It is instantiated twice, for the speculative and committed maps. Intra-group bypass stays in `rename_rat`.

## Test plan
1. **Reset then single rename:** after reset, rename slot0 `src1`=3, `dst`=5, `frl_regs[0]`=40 -> next cycle `psrc1`=3, `pdst`=40, `old_pdst`=5, `frl_acquire`=...0001.
2. **Intra-group bypass:** slot0 `dst`=7 (gets 41), slot1 `src1`=7, `dst`=7 (gets 42), slot2 `src2`=7 -> `psrc1[1]`=41, `old_pdst[1]`=41, `psrc2[2]`=42; `spec_map[7]`=42.
3. **Backpressure:**
   - `out_ready`=0 with `out_valid` high -> `in_ready`=0, `frl_acquire`=0, outputs held stable.
   - `frl_valid`=0 -> `in_ready`=0 with no acquire.
4. **Commit/free:** commit `dst`=5, `pdst`=40, `old_pdst`=5 -> next cycle `free_valid[0]`=1, `free_regs[0]`=5; `commit_map[5]`=40.
5. **Flush:** rename `dst`=9 to 43 uncommitted, then `flush` -> the next group reading `src`=9 gets 9; `out_valid` drops the cycle after the flush.
6. **Asynchronous reset mid-group:** assert `rst` between edges -> `out_valid` and `free_valid` go 0 immediately and the maps return to identity.
